hex_entry_bank: RTL and testbench
=================================

Name: hex_entry_bank

Overview:
- Parametrised multi-channel digit-entry register for the lab board datapath.
- Collects hex digits from switches into one of NCH operand registers, one digit per button press:
  - add shifts a digit in at the LSB end
  - del shifts one digit out
  - set loads a full word
  - clr zeroes the channel
- Tracks the digit count per channel and flags full/empty/error conditions.
- Drives the selected channel to the display and ALU operand logic.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of DIGIT_W.
- DIGIT_W, 4, bits per entered digit.
- NCH, 2, number of independent operand channels (≥1).
- OVERWRITE, 0, 1 = add on a full channel discards the MS digit; 0 = add on full is rejected.
- Derived: NDIG = DATA_W/DIGIT_W; LEN_W = $clog2(NDIG+1); SEL_W = max(1,$clog2(NCH)).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- din  in  DATA_W  word loaded by set
- hex  in  DIGIT_W  digit entered by add
- add  in  1  level button, already synchronised/debounced
- del  in  1  level button, already synchronised/debounced
- set  in  1  level button, already synchronised/debounced
- clr  in  1  level button, already synchronised/debounced
- sel  in  SEL_W  channel addressed by actions and shown on dout
- dout  out  DATA_W  data of channel sel (combinational mux of registers)
- len  out  LEN_W  digit count of channel sel
- full  out  1  len == NDIG for channel sel
- empty  out  1  len == 0 for channel sel
- err  out  1  one-cycle pulse on a rejected action

Behaviour:
- Reset (async, immediate):
  - all channel data = 0, all len = 0
  - edge-detector history = 0
  - err = 0
  - so dout = 0, len = 0, empty = 1, full = 0
- Edge detection:
  - Each button has a history FF; event = btn & ~btn_q.
  - A held button produces exactly one event.
  - A button already high when rst deasserts produces an event on the first clock.
- Action timing:
  - The action executes on the same clk edge that first samples the button high.
  - Result is visible on dout/len right after that edge (1-cycle latency from input change).
- Priority when several events occur in one cycle: set > clr > add > del.
  - Only the winner executes; losing events are consumed, not deferred.
- Targeting: the action applies to the channel indexed by sel in the event cycle. Other channels are unchanged.
- set: data = din; len = NDIG.
- clr: data = 0; len = 0.
- add:
  - not full: data = {data[DATA_W-DIGIT_W-1:0], hex}; len += 1.
  - full, OVERWRITE=1: same shift, MS digit lost, len stays NDIG, no err.
  - full, OVERWRITE=0: no change; err = 1 for one cycle.
- del:
  - not empty: data = data >> DIGIT_W (zero fill); len -= 1.
  - empty: no change; err = 1 for one cycle.
- err:
  - registered; high for exactly one cycle after the rejecting edge
  - 0 in all other cycles, including when no events occur
- sel:
  - changing sel alone causes no state change; dout/len/full/empty follow it combinationally
  - sel ≥ NCH (non-power-of-2 NCH): actions are ignored and no err is raised; dout = 0, len = 0, empty = 1
- Reset mid-operation: all state clears immediately; a button still held after reset generates a new event (see Edge detection).
- No internal counters wrap: len saturates at 0 and NDIG by rule.

Decomposition:
- Shared package entry_pkg:
  - action encoding enum (ACT_NONE, ACT_SET, ACT_CLR, ACT_ADD, ACT_DEL)
  - priority function mapping the event vector to an action
  - helper for LEN_W
- One sub-module, rise_pulse (1-bit history FF, async reset, event output), instantiated once per button.
- Channel storage is arrays of DATA_W data and LEN_W len inside hex_entry_bank.

Test Plan (DATA_W=32, DIGIT_W=4, NCH=2, OVERWRITE=0 unless stated):
- Reset, then press add 3× with hex=1,2,3 on sel=0 → dout=0x00000123, len=3; sel=1 shows dout=0, empty=1.
- Hold add high 10 cycles with hex=A → exactly one digit entered: 0x123 → 0x123A, len=4.
- set with din=0xDEADBEEF → len=8, full=1:
  - add with hex=5 → dout unchanged, err pulses 1 cycle
  - same test with OVERWRITE=1 → dout=0xEADBEEF5, len=8, err=0
- From 0x00000012, len=2: del ×3 → 0x1, then 0x0 with empty=1, then err pulse with dout still 0.
- Raise add, del and set in the same cycle with din=0x0000CAFE → set wins: dout=0x0000CAFE, len=8; no further change while all three are held.
- Assert rst mid-sequence on channel 1 holding 0xAB → all outputs zero immediately; after release, a held clr produces one event and err stays 0.

Source files
------------

// File: rtl/entry_pkg.sv
// Shared definitions for the hex entry bank.
//   action_t     : the single action executed in a cycle
//   BTN_*        : bit positions of the buttons inside the event vector
//   pick_action  : resolves simultaneous events to one action (set > clr > add > del)
//   len_w/sel_w  : width helpers for the digit counter and channel select
package entry_pkg;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_SET,
    ACT_CLR,
    ACT_ADD,
    ACT_DEL
  } action_t;

  localparam int NBTN    = 4;
  localparam int BTN_DEL = 0;
  localparam int BTN_ADD = 1;
  localparam int BTN_CLR = 2;
  localparam int BTN_SET = 3;

  // Losing events are simply dropped: the caller only ever sees the winner.
  function automatic action_t pick_action(input logic [NBTN-1:0] evt);
    if (evt[BTN_SET])      return ACT_SET;
    else if (evt[BTN_CLR]) return ACT_CLR;
    else if (evt[BTN_ADD]) return ACT_ADD;
    else if (evt[BTN_DEL]) return ACT_DEL;
    else                   return ACT_NONE;
  endfunction

  // Counter must hold 0..ndig inclusive.
  function automatic int len_w(input int ndig);
    return $clog2(ndig + 1);
  endfunction

  function automatic int sel_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector for one already-synchronised button.
//   clk : system clock
//   rst : asynchronous active-high reset (clears history)
//   btn : button level
//   evt : high in the cycle the button is first seen high
// History resets to 0, so a button held through reset fires once on the
// first clock after release.
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic btn_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_reg <= 1'b0;
    end else begin
      btn_reg <= btn;
    end
  end

  assign evt = btn & ~btn_reg;

endmodule

// File: rtl/hex_entry_bank.sv
// Multi-channel hex digit entry register.
// Each of NCH channels holds a DATA_W word and a digit count. Button events
// (one per press) act on the channel addressed by sel:
//   set : load din, count = NDIG
//   clr : zero data and count
//   add : shift hex in at the LSB end (rejected with err when full unless OVERWRITE)
//   del : shift one digit out with zero fill (rejected with err when empty)
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   din [DATA_W]          : word loaded by set
//   hex [DIGIT_W]         : digit entered by add
//   add, del, set, clr    : level buttons (synchronised, debounced)
//   sel [SEL_W]           : addressed channel, also the one shown on outputs
//   dout [DATA_W]         : data of channel sel (0 if sel is out of range)
//   len [LEN_W]           : digit count of channel sel
//   full, empty           : len == NDIG, len == 0
//   err                   : one-cycle pulse after a rejected action
module hex_entry_bank
  import entry_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int DIGIT_W   = 4,
  parameter  int NCH       = 2,
  parameter  int OVERWRITE = 0,
  localparam int NDIG      = DATA_W / DIGIT_W,
  localparam int LEN_W     = len_w(NDIG),
  localparam int SEL_W     = sel_w(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  din,
  input  logic [DIGIT_W-1:0] hex,
  input  logic               add,
  input  logic               del,
  input  logic               set,
  input  logic               clr,
  input  logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  dout,
  output logic [LEN_W-1:0]   len,
  output logic               full,
  output logic               empty,
  output logic               err
);

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(NDIG);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  // Button edge detection
  logic [NBTN-1:0] btn;
  logic [NBTN-1:0] evt;

  assign btn[BTN_SET] = set;
  assign btn[BTN_CLR] = clr;
  assign btn[BTN_ADD] = add;
  assign btn[BTN_DEL] = del;

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      rise_pulse u_rise (
        .clk (clk),
        .rst (rst),
        .btn (btn[gi]),
        .evt (evt[gi])
      );
    end
  endgenerate

  action_t act;
  assign act = pick_action(evt);

  // Channel storage
  logic [DATA_W-1:0] data_reg  [NCH];
  logic [DATA_W-1:0] data_next [NCH];
  logic [LEN_W-1:0]  len_reg   [NCH];
  logic [LEN_W-1:0]  len_next  [NCH];
  logic              err_reg;
  logic              err_next;

  // Out-of-range sel (non-power-of-2 NCH) reads as an empty, zero channel
  // and blocks every action, including the err pulse.
  logic              sel_ok;
  logic [DATA_W-1:0] cur_data;
  logic [LEN_W-1:0]  cur_len;
  logic              cur_full;
  logic              cur_empty;

  assign sel_ok = (32'(sel) < NCH);

  always_comb begin
    cur_data = '0;
    cur_len  = '0;
    if (sel_ok) begin
      cur_data = data_reg[sel];
      cur_len  = len_reg[sel];
    end
  end

  assign cur_full  = (cur_len == LEN_FULL);
  assign cur_empty = (cur_len == '0);

  always_comb begin
    data_next = data_reg;
    len_next  = len_reg;
    err_next  = 1'b0;
    if (sel_ok) begin
      case (act)
        ACT_SET: begin
          data_next[sel] = din;
          len_next[sel]  = LEN_FULL;
        end
        ACT_CLR: begin
          data_next[sel] = '0;
          len_next[sel]  = '0;
        end
        ACT_ADD: begin
          if (cur_full && (OVERWRITE == 0)) begin
            err_next = 1'b1;
          end else begin
            // Shift left drops the MS digit, which is only non-zero when full.
            data_next[sel] = (cur_data << DIGIT_W) | DATA_W'(hex);
            if (!cur_full) begin
              len_next[sel] = cur_len + LEN_ONE;
            end
          end
        end
        ACT_DEL: begin
          if (cur_empty) begin
            err_next = 1'b1;
          end else begin
            data_next[sel] = cur_data >> DIGIT_W;
            len_next[sel]  = cur_len - LEN_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        data_reg[c] <= '0;
        len_reg[c]  <= '0;
      end
      err_reg <= 1'b0;
    end else begin
      data_reg <= data_next;
      len_reg  <= len_next;
      err_reg  <= err_next;
    end
  end

  assign dout  = cur_data;
  assign len   = cur_len;
  assign full  = cur_full;
  assign empty = cur_empty;
  assign err   = err_reg;

endmodule

// File: tb/tb_hex_entry_bank.sv
// Bench for hex_entry_bank: two instances (OVERWRITE=0 and OVERWRITE=1)
// share all inputs; a value-level model of both is checked every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_hex_entry_bank;

  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  hex = '0;
  logic        add = 1'b0;
  logic        del = 1'b0;
  logic        set = 1'b0;
  logic        clr = 1'b0;
  logic [0:0]  sel = '0;

  logic [31:0] dout0, dout1;
  logic [3:0]  len0, len1;
  logic        full0, full1, empty0, empty1, err0, err1;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  hex_entry_bank #(.DATA_W(32), .DIGIT_W(4), .NCH(NCH), .OVERWRITE(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .hex(hex), .add(add), .del(del),
    .set(set), .clr(clr), .sel(sel), .dout(dout0), .len(len0),
    .full(full0), .empty(empty0), .err(err0)
  );

  hex_entry_bank #(.DATA_W(32), .DIGIT_W(4), .NCH(NCH), .OVERWRITE(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .hex(hex), .add(add), .del(del),
    .set(set), .clr(clr), .sel(sel), .dout(dout1), .len(len1),
    .full(full1), .empty(empty1), .err(err1)
  );

  // ---------------- model: index k = instance (k==1 overwrites) ----------
  logic [31:0] m_data [2][NCH];
  int          m_len  [2][NCH];
  bit          m_err  [2];
  logic [3:0]  p_btn;
  logic [3:0]  now_btn;
  logic [3:0]  ev;

  assign now_btn = {set, clr, add, del};
  assign ev      = now_btn & ~p_btn;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < NCH; c++) begin
          m_data[k][c] <= '0;
          m_len[k][c]  <= 0;
        end
        m_err[k] <= 1'b0;
      end
      p_btn <= '0;
    end else begin
      p_btn <= now_btn;
      for (int k = 0; k < 2; k++) begin
        m_err[k] <= 1'b0;
        if (int'(sel) < NCH) begin
          if (ev[3]) begin
            m_data[k][sel] <= din;
            m_len[k][sel]  <= 8;
          end else if (ev[2]) begin
            m_data[k][sel] <= 0;
            m_len[k][sel]  <= 0;
          end else if (ev[1]) begin
            if (m_len[k][sel] == 8 && k == 0) begin
              m_err[k] <= 1'b1;
            end else begin
              m_data[k][sel] <= 32'(m_data[k][sel] * 16 + 32'(hex));
              if (m_len[k][sel] < 8) m_len[k][sel] <= m_len[k][sel] + 1;
            end
          end else if (ev[0]) begin
            if (m_len[k][sel] == 0) begin
              m_err[k] <= 1'b1;
            end else begin
              m_data[k][sel] <= m_data[k][sel] / 16;
              m_len[k][sel]  <= m_len[k][sel] - 1;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_dout0",  dout0,         m_data[0][sel]);
      chk("cyc_len0",   32'(len0),     32'(m_len[0][sel]));
      chk("cyc_full0",  32'(full0),    32'(m_len[0][sel] == 8));
      chk("cyc_empty0", 32'(empty0),   32'(m_len[0][sel] == 0));
      chk("cyc_err0",   32'(err0),     32'(m_err[0]));
      chk("cyc_dout1",  dout1,         m_data[1][sel]);
      chk("cyc_len1",   32'(len1),     32'(m_len[1][sel]));
      chk("cyc_full1",  32'(full1),    32'(m_len[1][sel] == 8));
      chk("cyc_empty1", 32'(empty1),   32'(m_len[1][sel] == 0));
      chk("cyc_err1",   32'(err1),     32'(m_err[1]));
    end
  end

  // ---------------- directed stimulus -----------------------------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] mask);  // {set,clr,add,del}
    {set, clr, add, del} = mask;
    cyc();
    {set, clr, add, del} = 4'b0000;
    cyc();
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_dout0",  dout0, 32'h0);
    chk("rst_empty0", 32'(empty0), 32'd1);
    chk("rst_full0",  32'(full0),  32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // three digits into channel 0
    sel = 1'b0;
    hex = 4'h1; press(4'b0010);
    hex = 4'h2; press(4'b0010);
    hex = 4'h3; press(4'b0010);
    chk("t1_dout", dout0, 32'h0000_0123);
    chk("t1_len",  32'(len0), 32'd3);
    sel = 1'b1;
    #1;
    chk("t1_ch1_dout",  dout0, 32'h0);
    chk("t1_ch1_empty", 32'(empty0), 32'd1);
    sel = 1'b0;
    cyc();

    // held add enters exactly one digit
    hex = 4'hA;
    add = 1'b1;
    repeat (10) cyc();
    add = 1'b0;
    cyc();
    chk("t2_dout", dout0, 32'h0000_123A);
    chk("t2_len",  32'(len0), 32'd4);

    // full channel: reject vs overwrite
    din = 32'hDEAD_BEEF;
    press(4'b1000);
    chk("t3_len",  32'(len0), 32'd8);
    chk("t3_full", 32'(full0), 32'd1);
    hex = 4'h5;
    add = 1'b1;
    cyc();
    chk("t3_err0",  32'(err0), 32'd1);
    chk("t3_dout0", dout0, 32'hDEAD_BEEF);
    chk("t3_err1",  32'(err1), 32'd0);
    chk("t3_dout1", dout1, 32'hEADB_EEF5);
    chk("t3_len1",  32'(len1), 32'd8);
    add = 1'b0;
    cyc();
    chk("t3_err0_gone", 32'(err0), 32'd0);

    // delete down through empty
    press(4'b0100);
    hex = 4'h1; press(4'b0010);
    hex = 4'h2; press(4'b0010);
    chk("t4_start", dout0, 32'h0000_0012);
    press(4'b0001);
    chk("t4_del1", dout0, 32'h1);
    press(4'b0001);
    chk("t4_del2",   dout0, 32'h0);
    chk("t4_empty",  32'(empty0), 32'd1);
    del = 1'b1;
    cyc();
    chk("t4_err",    32'(err0), 32'd1);
    chk("t4_dout",   dout0, 32'h0);
    del = 1'b0;
    cyc();

    // simultaneous set/add/del: set wins, held buttons do nothing more
    din = 32'h0000_CAFE;
    hex = 4'h7;
    {set, add, del} = 3'b111;
    cyc();
    chk("t5_dout", dout0, 32'h0000_CAFE);
    chk("t5_len",  32'(len0), 32'd8);
    repeat (3) cyc();
    chk("t5_hold", dout0, 32'h0000_CAFE);
    {set, add, del} = 3'b000;
    cyc();

    // reset mid-sequence on channel 1
    sel = 1'b1;
    hex = 4'hA; press(4'b0010);
    hex = 4'hB; press(4'b0010);
    chk("t6_ch1", dout0, 32'h0000_00AB);
    clr = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_dout",  dout0, 32'h0);
    chk("t6_rst_len",   32'(len0), 32'd0);
    chk("t6_rst_empty", 32'(empty0), 32'd1);
    sel = 1'b0;
    #1;
    chk("t6_rst_ch0", dout0, 32'h0);
    sel = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_clr_err", 32'(err0), 32'd0);
    repeat (3) cyc();
    clr = 1'b0;
    cyc();

    // set held through reset fires once after release
    din = 32'h0000_5A5A;
    set = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t7_dout", dout0, 32'h0000_5A5A);
    chk("t7_len",  32'(len0), 32'd8);
    set = 1'b0;
    cyc();
    cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
